raster_to_mcu: RTL and testbench

Converts a raster-order YCbCr 4:4:4 pixel stream into 16x16 MCU order. Each MCU is emitted as four 8x8 blocks (top-left, top-right, bottom-left, bottom-right), with each block in raster order. The block sits directly upstream of `down_sampler`, whose slave port expects exactly this order and sideband. Ping-pong 16-line strip buffering sustains 1 pixel/cycle when the downstream is not stalled.

---
 rtl/raster_to_mcu.sv | 238 +++++++++++++++++++++++
 tb/tb_raster_to_mcu.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_to_mcu.sv
// raster_to_mcu: reorders a raster YCbCr 4:4:4 stream into 16x16 MCUs.
// Each MCU goes out as four 8x8 blocks (TL, TR, BL, BR), raster order
// inside a block. Two 16-line strip banks ping-pong between the writer
// and the reader. A 2-entry skid buffer drives the AXI-Stream master.
module raster_to_mcu #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        sync_err
);

  localparam int STRIPS = IMG_HEIGHT / 16;
  localparam int MCUS   = IMG_WIDTH / 16;
  localparam int XW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int SW     = (STRIPS > 1) ? $clog2(STRIPS) : 1;
  localparam int MW     = (MCUS > 1) ? $clog2(MCUS) : 1;

  localparam logic [XW-1:0] X_LAST     = XW'(IMG_WIDTH - 1);
  localparam logic [SW-1:0] STRIP_LAST = SW'(STRIPS - 1);
  localparam logic [MW-1:0] MCU_LAST   = MW'(MCUS - 1);

  if ((IMG_WIDTH % 16) != 0 || IMG_WIDTH < 16) begin : g_bad_width
    $error("raster_to_mcu: IMG_WIDTH must be a positive multiple of 16");
  end
  if ((IMG_HEIGHT % 16) != 0 || IMG_HEIGHT < 16) begin : g_bad_height
    $error("raster_to_mcu: IMG_HEIGHT must be a positive multiple of 16");
  end

  // One skid-buffer entry: pixel plus the block framing it carries.
  typedef struct packed {
    logic [23:0] data;
    logic        last;
    logic        user;
  } beat_t;

  // Strip storage: [bank][line within strip][column].
  logic [23:0] mem [2][16][IMG_WIDTH];

  logic [1:0] bank_full;
  logic [1:0] bank_full_next;

  // ---------------------------------------------------------------- write side
  logic          wr_bank;
  logic [XW-1:0] wr_x;
  logic [3:0]    wr_y;
  logic [SW-1:0] wr_strip;

  logic          wr_fire;
  logic          at_origin;
  logic          resync;
  logic [XW-1:0] eff_x;
  logic [3:0]    eff_y;
  logic [SW-1:0] eff_strip;
  logic          row_end;
  logic          set_full;
  logic          framing_err;

  assign s_axis_tready = !bank_full[wr_bank];
  assign wr_fire       = s_axis_tvalid && s_axis_tready;
  assign at_origin     = (wr_strip == '0) && (wr_x == '0) && (wr_y == '0);
  assign resync        = s_axis_tuser && !at_origin;

  // A misplaced frame start restarts the frame at the origin of this bank.
  assign eff_x     = resync ? '0 : wr_x;
  assign eff_y     = resync ? '0 : wr_y;
  assign eff_strip = resync ? '0 : wr_strip;
  assign row_end   = (eff_x == X_LAST);
  assign set_full  = wr_fire && row_end && (eff_y == 4'd15);

  assign framing_err = wr_fire && (resync || (!s_axis_tuser && at_origin) ||
                                   (s_axis_tlast != row_end));

  // Write position: column, then line, then bank/strip at the end of a strip.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank  <= 1'b0;
      wr_x     <= '0;
      wr_y     <= '0;
      wr_strip <= '0;
    end else if (wr_fire) begin
      if (row_end) begin
        wr_x <= '0;
        if (eff_y == 4'd15) begin
          wr_y     <= '0;
          wr_bank  <= ~wr_bank;
          wr_strip <= (eff_strip == STRIP_LAST) ? '0 : eff_strip + 1'b1;
        end else begin
          wr_y     <= eff_y + 4'd1;
          wr_strip <= eff_strip;
        end
      end else begin
        wr_x     <= eff_x + 1'b1;
        wr_y     <= eff_y;
        wr_strip <= eff_strip;
      end
    end
  end

  // Pixel store into the active write bank.
  // NOTE: the strip RAM has no reset; stale contents are never read because
  // a bank is only read after it has been completely rewritten.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][eff_y][eff_x] <= s_axis_tdata;
  end

  // Sticky framing error, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           sync_err <= 1'b0;
    else if (framing_err) sync_err <= 1'b1;
  end

  // ----------------------------------------------------------------- read side
  logic          rd_bank;
  logic [MW-1:0] mcu_x;
  logic [1:0]    blk;
  logic [2:0]    py;
  logic [2:0]    px;

  logic [3:0]    rd_row;
  logic [XW-1:0] rd_col;
  logic          rd_en;
  logic          rd_strip_end;
  logic          clr_full;
  logic          pop;
  beat_t         rd_beat;

  beat_t         sk_e0;
  beat_t         sk_e1;
  logic [1:0]    sk_count;

  assign rd_row = {blk[1], py};
  assign rd_col = XW'({mcu_x, blk[0], px});

  assign pop   = m_axis_tvalid && m_axis_tready;
  // The read lands in the skid buffer at the same edge, so one slot must be
  // free after this cycle's pop.
  assign rd_en = bank_full[rd_bank] && ((sk_count != 2'd2) || pop);

  assign rd_strip_end = (mcu_x == MCU_LAST) && (blk == 2'd3) &&
                        (py == 3'd7) && (px == 3'd7);
  assign clr_full     = rd_en && rd_strip_end;

  assign rd_beat.data = mem[rd_bank][rd_row][rd_col];
  assign rd_beat.last = (py == 3'd7) && (px == 3'd7);
  assign rd_beat.user = (py == 3'd0) && (px == 3'd0);

  // Read position: px, py, block, MCU; the bank flips after the strip's last read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank <= 1'b0;
      mcu_x   <= '0;
      blk     <= '0;
      py      <= '0;
      px      <= '0;
    end else if (rd_en) begin
      px <= px + 3'd1;
      if (px == 3'd7) begin
        py <= py + 3'd1;
        if (py == 3'd7) begin
          blk <= blk + 2'd1;
          if (blk == 2'd3) begin
            if (mcu_x == MCU_LAST) begin
              mcu_x   <= '0;
              rd_bank <= ~rd_bank;
            end else begin
              mcu_x <= mcu_x + 1'b1;
            end
          end
        end
      end
    end
  end

  // Bank ownership: writer sets an empty bank, reader clears a full one.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    bank_full_next = bank_full;
    if (set_full) bank_full_next[wr_bank] = 1'b1;
    if (clr_full) bank_full_next[rd_bank] = 1'b0;
  end

  // Bank flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bank_full <= 2'b00;
    else        bank_full <= bank_full_next;
  end

  // Two-entry skid buffer; the RAM read registers straight into it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sk_e0    <= '0;
      sk_e1    <= '0;
      sk_count <= 2'd0;
    end else begin
      case ({rd_en, pop})
        2'b10: begin
          if (sk_count == 2'd0) sk_e0 <= rd_beat;
          else                  sk_e1 <= rd_beat;
          sk_count <= sk_count + 2'd1;
        end
        2'b01: begin
          sk_e0    <= sk_e1;
          sk_count <= sk_count - 2'd1;
        end
        2'b11: begin
          if (sk_count == 2'd1) begin
            sk_e0 <= rd_beat;
          end else begin
            sk_e0 <= sk_e1;
            sk_e1 <= rd_beat;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axis_tvalid = (sk_count != 2'd0);
  assign m_axis_tdata  = sk_e0.data;
  assign m_axis_tlast  = sk_e0.last;
  assign m_axis_tuser  = sk_e0.user;

endmodule

// File: tb/tb_raster_to_mcu.sv
// Testbench for raster_to_mcu (32x32 image): an in-bench strip model
// predicts the MCU-order output stream; a monitor compares every output
// handshake and checks AXI hold behaviour while stalled.
module tb_raster_to_mcu;

  localparam int W = 32;
  localparam int H = 32;
  localparam int STRIP_PIX = 16 * W;
  localparam int FRAME_PIX = W * H;

  typedef struct packed {
    logic [23:0] d;
    logic        l;
    logic        u;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_last = 1'b0;
  logic        s_user = 1'b0;
  logic [23:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic        m_user;
  logic        sync_err;

  raster_to_mcu #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_data),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tlast  (s_last),
    .s_axis_tuser  (s_user),
    .m_axis_tdata  (m_data),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tlast  (m_last),
    .m_axis_tuser  (m_user),
    .sync_err      (sync_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  out_t        exp_q[$];
  logic [23:0] strip_buf [16][W];
  int          m_k = 0;       // pixel index within the current strip
  int          m_strip = 0;
  bit          m_err = 0;

  function automatic void model_reset();
    exp_q.delete();
    m_k = 0;
    m_strip = 0;
    m_err = 0;
  endfunction

  // Emit a completed strip: MCUs left to right, blocks TL/TR/BL/BR, raster inside.
  function automatic void model_emit();
    out_t o;
    for (int m = 0; m < W / 16; m++)
      for (int b = 0; b < 4; b++)
        for (int y = 0; y < 8; y++)
          for (int x = 0; x < 8; x++) begin
            o.d = strip_buf[(b / 2) * 8 + y][m * 16 + (b % 2) * 8 + x];
            o.u = (y == 0 && x == 0);
            o.l = (y == 7 && x == 7);
            exp_q.push_back(o);
          end
  endfunction

  function automatic void model_accept(input logic [23:0] d, input logic l, input logic u);
    bit origin;
    origin = (m_strip == 0 && m_k == 0);
    if (u && !origin) begin
      m_err = 1;
      m_k = 0;
      m_strip = 0;
    end else if (!u && origin) begin
      m_err = 1;
    end
    if (l != ((m_k % W) == W - 1)) m_err = 1;
    strip_buf[m_k / W][m_k % W] = d;
    m_k++;
    if (m_k == STRIP_PIX) begin
      model_emit();
      m_k = 0;
      m_strip = (m_strip + 1) % (H / 16);
    end
  endfunction

  // ---------------------------------------------------------------- ready driver
  bit rnd_mode = 0;
  bit m_ready_fixed = 1;

  always @(negedge clk) m_ready = rnd_mode ? 1'($urandom_range(0, 1)) : m_ready_fixed;

  // ---------------------------------------------------------------- monitor
  int          out_cnt = 0;
  logic [25:0] got [2048];
  bit          prev_stall = 0;
  logic [25:0] held = '0;
  bit          first_valid_seen = 0;
  int          first_valid_cyc = 0;
  bit          gap_on = 0;
  int          gap_cnt = 0;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_beat", 64'({m_data, m_last, m_user}), 64'(held));
      end
      if (m_valid && !first_valid_seen) begin
        first_valid_seen = 1;
        first_valid_cyc = cyc;
      end
      if (gap_on && !m_valid && out_cnt > 0 && out_cnt < FRAME_PIX) gap_cnt++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_output: got %0h expected no output", m_data);
        end else begin
          out_t e;
          e = exp_q.pop_front();
          check("out_beat", 64'({m_data, m_last, m_user}), 64'(e));
        end
        if (out_cnt < 2048) got[out_cnt] = {m_data, m_last, m_user};
        out_cnt++;
      end
      prev_stall = m_valid && !m_ready;
      held = {m_data, m_last, m_user};
    end
  end

  // ---------------------------------------------------------------- stimulus
  int in_stalls = 0;
  int last_in_cyc = 0;
  int strip0_end_cyc = 0;

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic send(input logic [23:0] d, input logic l, input logic u);
    int guard = 0;
    s_data = d;
    s_last = l;
    s_user = u;
    s_valid = 1'b1;
    while (!s_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
      in_stalls++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got s_axis_tready=0 expected 1 within 5000 cycles");
    end else begin
      model_accept(d, l, u);
      last_in_cyc = cyc;
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Pixels [first, first+n) of a frame; data = {row, col, pat}.
  task automatic send_pixels(input logic [7:0] pat, input int first, input int n);
    for (int p = first; p < first + n; p++) begin
      int r, c;
      r = p / W;
      c = p % W;
      send({8'(r), 8'(c), pat}, (c == W - 1), (p == 0));
      if (p == STRIP_PIX - 1) strip0_end_cyc = last_in_cyc;
    end
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while ((exp_q.size() != 0 || m_valid) && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d pixels outstanding expected 0", name, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int guard;

    // ---- reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tvalid", 64'(m_valid), 64'd0);
    check("rst_tdata", 64'(m_data), 64'd0);
    check("rst_tlast", 64'(m_last), 64'd0);
    check("rst_tuser", 64'(m_user), 64'd0);
    check("rst_sync_err", 64'(sync_err), 64'd0);
    check("rst_tready", 64'(s_ready), 64'd1);

    // ---- order check, downstream always ready
    m_ready_fixed = 1;
    out_cnt = 0;
    first_valid_seen = 0;
    send_pixels(8'h00, 0, FRAME_PIX);
    wait_drain("order");
    check("order_latency", 64'(first_valid_cyc - strip0_end_cyc), 64'd2);
    check("order_px0", 64'(got[0]), 64'({8'd0, 8'd0, 8'h00, 1'b0, 1'b1}));
    check("order_px63", 64'(got[63]), 64'({8'd7, 8'd7, 8'h00, 1'b1, 1'b0}));
    check("order_px64", 64'(got[64]), 64'({8'd0, 8'd8, 8'h00, 1'b0, 1'b1}));
    check("order_px128", 64'(got[128]), 64'({8'd8, 8'd0, 8'h00, 1'b0, 1'b1}));
    check("order_px192", 64'(got[192]), 64'({8'd8, 8'd8, 8'h00, 1'b0, 1'b1}));
    check("order_px256", 64'(got[256]), 64'({8'd0, 8'd16, 8'h00, 1'b0, 1'b1}));
    check("order_count", 64'(out_cnt), 64'(FRAME_PIX));
    check("order_sync_err", 64'(sync_err), 64'd0);

    // ---- random backpressure
    rnd_mode = 1;
    out_cnt = 0;
    send_pixels(8'h5A, 0, FRAME_PIX);
    wait_drain("bp");
    rnd_mode = 0;
    m_ready_fixed = 1;
    check("bp_count", 64'(out_cnt), 64'(FRAME_PIX));

    // ---- ping-pong full: downstream stalled
    m_ready_fixed = 0;
    @(negedge clk);
    out_cnt = 0;
    in_stalls = 0;
    send_pixels(8'hC3, 0, FRAME_PIX);
    check("pp_no_stall", 64'(in_stalls), 64'd0);
    check("pp_ready_low", 64'(s_ready), 64'd0);
    repeat (20) @(negedge clk);
    check("pp_ready_still_low", 64'(s_ready), 64'd0);
    check("pp_no_output", 64'(out_cnt), 64'd0);
    m_ready_fixed = 1;
    guard = 0;
    while (!s_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("pp_ready_back", 64'(s_ready), 64'd1);
    check("pp_release_point", 64'(out_cnt >= 510 && out_cnt <= 512), 64'd1);
    wait_drain("pp");
    check("pp_count", 64'(out_cnt), 64'(FRAME_PIX));

    // ---- streaming: both sides ready, no gaps
    out_cnt = 0;
    in_stalls = 0;
    gap_cnt = 0;
    gap_on = 1;
    send_pixels(8'h33, 0, FRAME_PIX);
    wait_drain("stream");
    gap_on = 0;
    check("stream_in_stalls", 64'(in_stalls), 64'd0);
    check("stream_out_gaps", 64'(gap_cnt), 64'd0);
    check("stream_count", 64'(out_cnt), 64'(FRAME_PIX));

    // ---- resync: frame start injected at pixel 100 of strip 0
    out_cnt = 0;
    send_pixels(8'h11, 0, 100);
    check("resync_err_before", 64'(sync_err), 64'd0);
    send_pixels(8'h77, 0, FRAME_PIX);
    wait_drain("resync");
    check("resync_err", 64'(sync_err), 64'd1);
    check("resync_err_model", 64'(sync_err), 64'(m_err));
    check("resync_first", 64'(got[0]), 64'({8'd0, 8'd0, 8'h77, 1'b0, 1'b1}));
    check("resync_count", 64'(out_cnt), 64'(FRAME_PIX));
    repeat (10) @(negedge clk);
    check("resync_err_sticky", 64'(sync_err), 64'd1);

    // ---- reset in the middle of a block
    out_cnt = 0;
    send_pixels(8'hAA, 0, STRIP_PIX);
    guard = 0;
    while (out_cnt != 70 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("midrst_reached_70", 64'(out_cnt), 64'd70);
    rst_n = 1'b0;
    model_reset();
    #2;
    check("midrst_tvalid", 64'(m_valid), 64'd0);
    check("midrst_tdata", 64'(m_data), 64'd0);
    check("midrst_tlast", 64'(m_last), 64'd0);
    check("midrst_tuser", 64'(m_user), 64'd0);
    check("midrst_sync_err", 64'(sync_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_tready", 64'(s_ready), 64'd1);
    out_cnt = 0;
    send_pixels(8'h99, 0, FRAME_PIX);
    wait_drain("midrst");
    check("midrst_first", 64'(got[0]), 64'({8'd0, 8'd0, 8'h99, 1'b0, 1'b1}));
    check("midrst_px64", 64'(got[64]), 64'({8'd0, 8'd8, 8'h99, 1'b0, 1'b1}));
    check("midrst_count", 64'(out_cnt), 64'(FRAME_PIX));
    check("midrst_sync_err_end", 64'(sync_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
